mdu_ctrl: RTL

Multi-cycle multiply/divide sequencer that sits beside the E-stage ALU in the pipelined CPU and owns the HI/LO registers. It accepts mult/multu/div/divu/mthi/mtlo commands, holds them for a fixed cycle count, and raises busy so the hazard unit stalls later HI/LO users. It also serves mfhi/mflo reads combinationally.

---
 rtl/mdu_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multi-cycle multiply/divide sequencer owning HI/LO
//
// Accepts mult/multu/div/divu/mthi/mtlo from the E stage. Arithmetic ops
// hold busy for a fixed number of cycles and then commit to HI/LO.
// mthi/mtlo write directly in the issuing edge.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-low reset
//   start    - command valid, sampled on the rising edge
//   mdOp     - 0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo 6/7=no-op
//   srcA     - rs operand
//   srcB     - rt operand
//   hiloSel  - read select, 1=HI 0=LO
//   busy     - multi-cycle operation in flight
//   mdOut    - committed HI or LO, combinational on hiloSel
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdOp,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        hiloSel,
  output logic        busy,
  output logic [31:0] mdOut
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [1:0]    op_q;
  logic [31:0]   a_q, b_q;
  logic [31:0]   hi, lo;

  logic          issue_arith;
  logic          finish;

  assign issue_arith = (state == IDLE) && start && !mdOp[2];
  // The cycle holding cnt==1 is the last busy cycle; its closing edge commits.
  assign finish      = (state == RUN) && (cnt == CW'(1));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    case (state)
      IDLE: begin
        if (issue_arith) begin
          state_n = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (finish) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand latch and cycle counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      op_q <= 2'd0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
    end else if (issue_arith) begin
      cnt  <= mdOp[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      op_q <= mdOp[1:0];
      a_q  <= srcA;
      b_q  <= srcB;
    end else if (state == RUN) begin
      cnt <= cnt - CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Arithmetic on the latched operands only
  // ---------------------------------------------------------------------------
  logic signed [63:0] a_sx, b_sx, prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] abs_a, abs_b, den_s, den_u;
  logic        [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

  always_comb begin
    a_sx   = {{32{a_q[31]}}, a_q};
    b_sx   = {{32{b_q[31]}}, b_q};
    prod_s = a_sx * b_sx;
    prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide on magnitudes: 0x80000000 maps to magnitude 2^31, so the
    // 0x80000000 / -1 overflow naturally yields quotient 0x80000000, rem 0.
    abs_a  = a_q[31] ? (~a_q + 32'd1) : a_q;
    abs_b  = b_q[31] ? (~b_q + 32'd1) : b_q;
    // Zero divisors are replaced so the divider never sees 0; the commit
    // logic skips the write in that case.
    den_s  = (abs_b == 32'd0) ? 32'd1 : abs_b;
    den_u  = (b_q == 32'd0) ? 32'd1 : b_q;
    q_mag  = abs_a / den_s;
    r_mag  = abs_a % den_s;
    q_s    = (a_q[31] ^ b_q[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s    = a_q[31] ? (~r_mag + 32'd1) : r_mag;
    q_u    = a_q / den_u;
    r_u    = a_q % den_u;
  end

  // ---------------------------------------------------------------------------
  // HI/LO registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (finish) begin
      case (op_q)
        2'd0: begin
          hi <= prod_s[63:32];
          lo <= prod_s[31:0];
        end
        2'd1: begin
          hi <= prod_u[63:32];
          lo <= prod_u[31:0];
        end
        2'd2: begin
          if (b_q != 32'd0) begin
            hi <= r_s;
            lo <= q_s;
          end
        end
        default: begin
          if (b_q != 32'd0) begin
            hi <= r_u;
            lo <= q_u;
          end
        end
      endcase
    end else if ((state == IDLE) && start) begin
      if (mdOp == 3'd4) begin
        hi <= srcA;
      end else if (mdOp == 3'd5) begin
        lo <= srcA;
      end
    end
  end

  assign mdOut = hiloSel ? hi : lo;

endmodule
